// File: rtl/error_report_arbiter_if.sv
// error_report_arbiter_if: source/FIFO-side bus of the error report arbiter.
// DROP_CNT exists only when ERR_ARB_DROP_CNT_EN is defined.
interface error_report_arbiter_if #(
   parameter int N     = 4,
   parameter int EW    = 29,
   parameter int DEPTH = 64
);
   logic [N-1:0]               SRC_STB;
   logic [N*EW-1:0]            SRC_ECD;
   logic                       CONT_STB;
   logic                       FIFO_VALID;
   logic                       FIFO_ERD;
   logic                       OUT_STB;
   logic [EW-1:0]              OUT_ECD;
   logic [$clog2(DEPTH)-1:0]   CREDITS;
   logic [N-1:0]               OVF;
   logic                       OVF_CONT;
   logic                       OVF_CLR;
`ifdef ERR_ARB_DROP_CNT_EN
   logic [15:0]                DROP_CNT;
   modport slave (
      input  SRC_STB, SRC_ECD, CONT_STB, FIFO_VALID, FIFO_ERD, OVF_CLR,
      output OUT_STB, OUT_ECD, CREDITS, OVF, OVF_CONT, DROP_CNT
   );
   modport master (
      output SRC_STB, SRC_ECD, CONT_STB, FIFO_VALID, FIFO_ERD, OVF_CLR,
      input  OUT_STB, OUT_ECD, CREDITS, OVF, OVF_CONT, DROP_CNT
   );
`else
   modport slave (
      input  SRC_STB, SRC_ECD, CONT_STB, FIFO_VALID, FIFO_ERD, OVF_CLR,
      output OUT_STB, OUT_ECD, CREDITS, OVF, OVF_CONT
   );
   modport master (
      output SRC_STB, SRC_ECD, CONT_STB, FIFO_VALID, FIFO_ERD, OVF_CLR,
      input  OUT_STB, OUT_ECD, CREDITS, OVF, OVF_CONT
   );
`endif
endinterface

// File: rtl/error_report_arbiter.sv
// error_report_arbiter: round-robin sharing of the FIFO core-error port among N sources,
// with strobe spacing and credit tracking. ERR_ARB_DROP_CNT_EN adds a saturating DROP_CNT.
module error_report_arbiter #(
   parameter int N     = 4,
   parameter int EW    = 29,
   parameter int DEPTH = 64
) (
   input logic                   CLK,
   input logic                   RESET,
   error_report_arbiter_if.slave bus
);
   localparam int CW = $clog2(DEPTH);
   localparam int RW = $clog2(N);
   localparam logic [RW:0] NV = (RW+1)'(N);
   localparam logic [CW:0] MAXC = (CW+1)'(DEPTH-1);

   logic [N-1:0]  pend_q, pend_d, rot, grant, load, drop, ovf_q, ovf_d;
   logic [EW-1:0] pend_ecd_q [N];
   logic [EW-1:0] out_ecd_q;
   logic [RW-1:0] rr_q, rr_d, off, grant_idx;
   logic [RW:0]   idx_sum, rr_sum;
   logic [CW-1:0] credits_q, credits_d;
   logic [CW:0]   cr_sum, cr_dec, cr_diff;
   logic          gap_q, out_stb_q, ovf_cont_q, ovf_cont_d, issue, found, inc, cont_drop;
`ifdef ERR_ARB_DROP_CNT_EN
   logic [15:0]   drop_cnt_q, drop_cnt_d;
   logic [16:0]   drop_sum;
`endif

   always_comb begin
      // rotate so bit 0 is the source at RR; first set bit is the grant offset
      rot = N'({pend_q, pend_q} >> rr_q);
      off = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) if (!found && rot[k]) begin found = 1'b1; off = RW'(k); end
      idx_sum = {1'b0, rr_q} + {1'b0, off};
      grant_idx = idx_sum >= NV ? RW'(idx_sum - NV) : idx_sum[RW-1:0];
      issue = |pend_q & ~gap_q & (credits_q != '0);
      grant = issue ? N'(1) << grant_idx : '0;
      load = bus.SRC_STB & (~pend_q | grant);
      drop = bus.SRC_STB & pend_q & ~grant;
      pend_d = load | (pend_q & ~grant);
      rr_sum = {1'b0, grant_idx} + (RW+1)'(1);
      rr_d = issue ? (rr_sum == NV ? '0 : rr_sum[RW-1:0]) : rr_q;
      inc = bus.FIFO_ERD & bus.FIFO_VALID;
      cont_drop = bus.CONT_STB & (credits_q == '0) & ~inc;
      cr_sum = {1'b0, credits_q} + (CW+1)'(inc);
      cr_dec = (CW+1)'(issue) + (CW+1)'(bus.CONT_STB);
      cr_diff = cr_sum - cr_dec;
      credits_d = cr_sum < cr_dec ? '0 : cr_diff > MAXC ? MAXC[CW-1:0] : cr_diff[CW-1:0];
      ovf_d = (bus.OVF_CLR ? '0 : ovf_q) | drop;
      ovf_cont_d = (bus.OVF_CLR ? 1'b0 : ovf_cont_q) | cont_drop;
`ifdef ERR_ARB_DROP_CNT_EN
      drop_sum = {1'b0, bus.OVF_CLR ? 16'd0 : drop_cnt_q} + 17'($countones(drop)) + 17'(cont_drop);
      drop_cnt_d = drop_sum[16] ? '1 : drop_sum[15:0];
`endif
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         pend_q <= '0;
         for (int i = 0; i < N; i++) pend_ecd_q[i] <= '0;
         rr_q <= '0;
         gap_q <= 1'b0;
         out_stb_q <= 1'b0;
         out_ecd_q <= '0;
         credits_q <= MAXC[CW-1:0];
         ovf_q <= '0;
         ovf_cont_q <= 1'b0;
`ifdef ERR_ARB_DROP_CNT_EN
         drop_cnt_q <= '0;
`endif
      end else begin
         pend_q <= pend_d;
         for (int i = 0; i < N; i++) if (load[i]) pend_ecd_q[i] <= bus.SRC_ECD[i*EW +: EW];
         rr_q <= rr_d;
         gap_q <= issue;
         out_stb_q <= issue;
         if (issue) out_ecd_q <= pend_ecd_q[grant_idx];
         credits_q <= credits_d;
         ovf_q <= ovf_d;
         ovf_cont_q <= ovf_cont_d;
`ifdef ERR_ARB_DROP_CNT_EN
         drop_cnt_q <= drop_cnt_d;
`endif
      end
   end

   assign bus.OUT_STB = out_stb_q;
   assign bus.OUT_ECD = out_ecd_q;
   assign bus.CREDITS = credits_q;
   assign bus.OVF = ovf_q;
   assign bus.OVF_CONT = ovf_cont_q;
`ifdef ERR_ARB_DROP_CNT_EN
   assign bus.DROP_CNT = drop_cnt_q;
`endif
endmodule

// File: tb/tb_error_report_arbiter.sv
// tb_error_report_arbiter: directed plus randomized checks of error_report_arbiter
// against a cycle-level reference model kept in the bench.
module tb_error_report_arbiter;
   localparam int N = 4, EW = 29, DEPTH = 64;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   error_report_arbiter_if #(.N(N), .EW(EW), .DEPTH(DEPTH)) bus();
   error_report_arbiter #(.N(N), .EW(EW), .DEPTH(DEPTH)) dut (.CLK(clk), .RESET(rst_n), .bus(bus));

   int total = 0, bad = 0;
   bit m_pend [N];
   logic [EW-1:0] m_code [N];
   logic [EW-1:0] m_ecd;
   logic [N-1:0] m_ovf;
   bit m_gap, m_stb, m_ovfc, prev_stb;
   int m_rr, m_cred, m_drops;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task mreset;
      for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_code[i] = '0; end
      m_ecd = '0; m_ovf = '0; m_gap = 0; m_stb = 0; m_ovfc = 0;
      m_rr = 0; m_cred = DEPTH - 1; m_drops = 0; prev_stb = 0;
   endtask

   task mstep;
      int g, nd, cr;
      bit any, iss, inc;
      any = 0;
      for (int i = 0; i < N; i++) any |= m_pend[i];
      iss = any && !m_gap && m_cred > 0;
      g = -1;
      if (iss) for (int k = 0; k < N; k++) if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
      if (bus.OVF_CLR) begin m_ovf = '0; m_ovfc = 0; m_drops = 0; end
      m_stb = iss;
      if (iss) m_ecd = m_code[g];
      nd = 0;
      for (int i = 0; i < N; i++) begin
         if (bus.SRC_STB[i]) begin
            if (!m_pend[i] || i == g) begin m_code[i] = bus.SRC_ECD[i*EW +: EW]; m_pend[i] = 1; end
            else begin m_ovf[i] = 1'b1; nd++; end
         end else if (i == g) m_pend[i] = 0;
      end
      inc = bus.FIFO_ERD && bus.FIFO_VALID;
      if (bus.CONT_STB && m_cred == 0 && !inc) begin m_ovfc = 1; nd++; end
      cr = m_cred + int'(inc) - int'(iss) - int'(bus.CONT_STB);
      m_cred = cr < 0 ? 0 : cr > DEPTH - 1 ? DEPTH - 1 : cr;
      m_drops = m_drops + nd > 65535 ? 65535 : m_drops + nd;
      m_gap = iss;
      if (iss) m_rr = (g + 1) % N;
   endtask

   always @(posedge clk) begin
      if (!rst_n) mreset(); else mstep();
      #1;
      chk("out_stb", 64'(bus.OUT_STB), 64'(m_stb));
      chk("out_ecd", 64'(bus.OUT_ECD), 64'(m_ecd));
      chk("credits", 64'(bus.CREDITS), 64'(m_cred));
      chk("ovf", 64'(bus.OVF), 64'(m_ovf));
      chk("ovf_cont", 64'(bus.OVF_CONT), 64'(m_ovfc));
`ifdef ERR_ARB_DROP_CNT_EN
      chk("drop_cnt", 64'(bus.DROP_CNT), 64'(m_drops));
`endif
      chk("no_b2b", 64'(bus.OUT_STB & prev_stb), 64'd0);
      prev_stb = bus.OUT_STB;
   end

   task tick;
      @(negedge clk);
   endtask

   task clear_in;
      bus.SRC_STB = '0; bus.SRC_ECD = '0; bus.CONT_STB = 0;
      bus.FIFO_VALID = 0; bus.FIFO_ERD = 0; bus.OVF_CLR = 0;
   endtask

   task do_reset;
      rst_n = 0;
      clear_in();
      tick(); tick();
      rst_n = 1;
      tick();
   endtask

   logic [EW-1:0] codes [N];

   initial begin
      clear_in();
      do_reset();
      chk("rst_out_stb", 64'(bus.OUT_STB), 64'd0);
      chk("rst_out_ecd", 64'(bus.OUT_ECD), 64'd0);
      chk("rst_credits", 64'(bus.CREDITS), 64'd63);
      chk("rst_ovf", 64'(bus.OVF), 64'd0);
      chk("rst_ovf_cont", 64'(bus.OVF_CONT), 64'd0);

      // single report from source 2
      bus.SRC_STB = 4'b0100; bus.SRC_ECD[2*EW +: EW] = 29'h0ABCDEF;
      tick(); clear_in();
      chk("single_t1_stb", 64'(bus.OUT_STB), 64'd0);
      tick();
      chk("single_stb", 64'(bus.OUT_STB), 64'd1);
      chk("single_ecd", 64'(bus.OUT_ECD), 64'h0ABCDEF);
      chk("single_credits", 64'(bus.CREDITS), 64'd62);
      tick();
      chk("single_stb_low", 64'(bus.OUT_STB), 64'd0);

      // all sources at once, RR=0
      do_reset();
      codes[0] = 29'h1000001; codes[1] = 29'h0200002; codes[2] = 29'h0030003; codes[3] = 29'h1FFFFFF;
      bus.SRC_STB = '1;
      for (int i = 0; i < N; i++) bus.SRC_ECD[i*EW +: EW] = codes[i];
      tick(); clear_in();
      for (int k = 0; k < N; k++) begin
         tick();
         chk("rr_stb", 64'(bus.OUT_STB), 64'd1);
         chk("rr_ecd", 64'(bus.OUT_ECD), 64'(codes[k]));
         if (k == N - 1) chk("rr_credits", 64'(bus.CREDITS), 64'd59);
         tick();
         chk("rr_gap", 64'(bus.OUT_STB), 64'd0);
      end

      // source 1 strobes twice while source 0 holds the grant
      do_reset();
      bus.SRC_STB = 4'b0011; tick();
      bus.SRC_STB = 4'b0010; tick();
      clear_in();
      chk("drop_ovf", 64'(bus.OVF), 64'd2);
`ifdef ERR_ARB_DROP_CNT_EN
      chk("drop_cnt1", 64'(bus.DROP_CNT), 64'd1);
`endif
      bus.OVF_CLR = 1; tick(); bus.OVF_CLR = 0;
      chk("clr_ovf", 64'(bus.OVF), 64'd0);
      repeat (6) tick();

      // credit exhaustion and single-credit recovery
      do_reset();
      for (int k = 0; k < DEPTH - 1; k++) begin
         bus.SRC_STB = 4'(1 << (k % N)); tick(); clear_in(); tick(); tick();
      end
      chk("exh_credits", 64'(bus.CREDITS), 64'd0);
      bus.SRC_STB = 4'b0001; bus.SRC_ECD[0 +: EW] = 29'h1234567; tick(); clear_in();
      repeat (4) begin
         tick();
         chk("exh_hold_stb", 64'(bus.OUT_STB), 64'd0);
      end
      bus.FIFO_VALID = 1; bus.FIFO_ERD = 1; tick(); clear_in();
      chk("ret_credits", 64'(bus.CREDITS), 64'd1);
      chk("ret_stb_wait", 64'(bus.OUT_STB), 64'd0);
      tick();
      chk("ret_stb", 64'(bus.OUT_STB), 64'd1);
      chk("ret_ecd", 64'(bus.OUT_ECD), 64'h1234567);
      chk("ret_credits0", 64'(bus.CREDITS), 64'd0);
      tick();
      bus.CONT_STB = 1; tick(); clear_in();
      chk("cont_ovf", 64'(bus.OVF_CONT), 64'd1);
      chk("cont_credits", 64'(bus.CREDITS), 64'd0);
`ifdef ERR_ARB_DROP_CNT_EN
      chk("cont_drop_cnt", 64'(bus.DROP_CNT), 64'd1);
`endif

      // reset while reports are pending
      do_reset();
      bus.SRC_STB = 4'b0111; tick(); clear_in();
      rst_n = 0; #1;
      chk("mid_rst_stb", 64'(bus.OUT_STB), 64'd0);
      chk("mid_rst_credits", 64'(bus.CREDITS), 64'd63);
      tick(); tick(); rst_n = 1;
      repeat (10) begin
         tick();
         chk("post_rst_quiet", 64'(bus.OUT_STB), 64'd0);
      end

      // randomized traffic with read-rate phases
      for (int c = 0; c < 3000; c++) begin
         int ph;
         ph = (c / 250) % 3;
         for (int i = 0; i < N; i++) begin
            bus.SRC_STB[i] = $urandom_range(0, 3) == 0;
            bus.SRC_ECD[i*EW +: EW] = EW'($urandom());
         end
         bus.CONT_STB = $urandom_range(0, 19) == 0;
         bus.FIFO_VALID = $urandom_range(0, 1) == 1;
         bus.FIFO_ERD = ph == 0 ? $urandom_range(0, 1) == 1 : ph == 2 ? $urandom_range(0, 3) == 0 : 1'b0;
         bus.OVF_CLR = $urandom_range(0, 49) == 0;
         if (c == 1500) rst_n = 0;
         if (c == 1502) rst_n = 1;
         tick();
      end
      clear_in();
      tick(); tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/error_report_arbiter.md
Name: error_report_arbiter

Overview:
- Shares the single core-error write port of the error FIFO (strobe plus 29-bit code) among N error sources: execution units, MMU and bus watchdog.
- Holds one pending report per source and grants sources round-robin.
- Spaces strobes so the FIFO's edge-detecting strobe register never merges two back-to-back reports.
- Tracks FIFO occupancy with credits, because the FIFO has no full flag and wraps silently at 64 entries.

Parameters:
- N, 4, number of error sources (2..8).
- EW, 29, error code width; matches the FIFO core-code input.
- DEPTH, 64, FIFO entries; usable capacity is DEPTH-1 because the FIFO pointers use an equality empty test.

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-low reset.
- SRC_STB  in  N  per-source error strobe, one cycle per report.
- SRC_ECD  in  N*EW  per-source code; source i occupies bits [i*EW +: EW].
- CONT_STB  in  1  context-controller report strobe; it writes the same FIFO directly and consumes a credit.
- FIFO_VALID  in  1  FIFO read-side VALID, monitored only.
- FIFO_ERD  in  1  FIFO read strobe, monitored only.
- OUT_STB  out  1  strobe to the FIFO core-error input.
- OUT_ECD  out  EW  code to the FIFO core-error input.
- CREDITS  out  log2(DEPTH)  free FIFO entries.
- OVF  out  N  sticky per-source drop flags.
- OVF_CONT  out  1  sticky flag: CONT_STB arrived with zero credits.
- OVF_CLR  in  1  synchronous clear of OVF and OVF_CONT.

Behaviour:
- Reset values:
  - OUT_STB=0, OUT_ECD=0.
  - CREDITS=DEPTH-1 (63).
  - OVF=0, OVF_CONT=0.
  - All pending flags 0; round-robin pointer RR=0; GAP=0.
- Capture, per source i:
  - If SRC_STB[i] is high and pend[i]=0, or source i is granted this cycle: load pend_ecd[i] and set pend[i].
  - If SRC_STB[i] is high while pend[i]=1 and source i is not granted: drop the new report, keep the old one, set OVF[i].
- Grant condition: issue=|pend & ~GAP & (CREDITS!=0).
- Selection: the first pending source at or after RR, wrapping modulo N.
- On a grant to source g:
  - OUT_STB<=1, OUT_ECD<=pend_ecd[g].
  - Clear pend[g] unless it is reloaded in the same cycle.
  - RR<=(g+1) mod N.
- Otherwise OUT_STB<=0 and OUT_ECD holds its last value.
- GAP<=issue. OUT_STB is never high on two consecutive cycles, so the maximum issue rate is 1 per 2 cycles.
- Latency: with the arbiter idle, SRC_STB at cycle t leads to OUT_STB at cycle t+2.
- Credits per cycle: dec = issue + CONT_STB (0..2); inc = FIFO_ERD & FIFO_VALID.
  - CREDITS <= CREDITS - dec + inc, saturating at 0 and at DEPTH-1.
  - issue requires CREDITS>=1. If CONT_STB and issue coincide with CREDITS==1, CREDITS ends at 0.
  - If CONT_STB arrives while CREDITS==0 and inc==0: set OVF_CONT; CREDITS stays 0.
  - A simultaneous issue and return leaves CREDITS unchanged.
- Clearing: OVF_CLR clears the flags. A drop or set event in the same cycle wins, so the flag stays 1.
- Pending state: pending reports persist indefinitely while CREDITS==0 and issue resumes on the first returned credit.
- Reset mid-operation: all pending reports are discarded and CREDITS returns to DEPTH-1. The FIFO is reset by the same RESET.

Optional Feature:
- Macro: ERR_ARB_DROP_CNT_EN.
- Defined:
  - Adds output DROP_CNT[15:0], a saturating count of all dropped reports (SRC and CONT).
  - Multiple drops in one cycle add their popcount.
  - Cleared by OVF_CLR; increments in the clear cycle are applied after the clear.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Single report: SRC_STB[2] with code 0x0ABCDEF at cycle 10 -> OUT_STB high in cycle 12 only, OUT_ECD=0x0ABCDEF, CREDITS 63->62.
- All N=4 sources strobe in cycle 5 with RR=0 -> OUT_STB in cycles 7, 9, 11, 13 granting sources 0, 1, 2, 3; no consecutive strobes; CREDITS=59.
- Source 1 strobes in cycles 5 and 6 with source 0 also pending -> second report dropped and OVF[1]=1 from cycle 7; after OVF_CLR, OVF=0.
- Credit exhaustion:
  - Issue 63 reports with no reads -> CREDITS=0 and OUT_STB stays low with a report pending.
  - One FIFO_ERD&FIFO_VALID cycle -> one issue follows 2 cycles later and CREDITS returns to 0.
- CONT_STB with CREDITS=0 -> OVF_CONT=1 and CREDITS stays 0. With ERR_ARB_DROP_CNT_EN, DROP_CNT increments by 1.
- Assert RESET while 3 reports are pending -> OUT_STB=0 and CREDITS=63; after release, no strobes occur.
